// File: rtl/debug_reg_tx_if.sv
// Debug register transmitter bus: CPDR strobe in, UART line and status out.
interface debug_reg_tx_if;
    logic [31:0] dr_in;
    logic        dr_valid;
    logic        tx;
    logic        busy;
    logic        overflow;

    modport master (
        output dr_in,
        output dr_valid,
        input  tx,
        input  busy,
        input  overflow
    );

    modport slave (
        input  dr_in,
        input  dr_valid,
        output tx,
        output busy,
        output overflow
    );
endinterface

// File: rtl/debug_reg_tx.sv
// Debug register UART transmitter: buffers 32-bit CPDR writes in a FIFO and
// prints each one as 8 upper-case hex digits followed by CR LF (8N1, LSB first).
// Optional build macro DEBUG_REG_TX_DEDUP_EN: a strobe repeating the last
// accepted value (0 after reset) is silently ignored.
module debug_reg_tx #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    debug_reg_tx_if.slave bus
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [31:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     bit_q, bit_d;
    logic [3:0]     char_q, char_d;
    logic [31:0]    shift_q, shift_d;
    logic           ovf_q;

    logic           pop, push, drop, dup, full, tick;
    logic [3:0]     nib;
    logic [7:0]     chr;
    logic           tx_w;

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = (state_q == LOAD);
    assign tick = (timer_q == TW'(CLK_DIV - 1));

`ifdef DEBUG_REG_TX_DEDUP_EN
    logic [31:0] last_q;

    assign dup = bus.dr_valid && (bus.dr_in == last_q);

    // Remember the last accepted value for duplicate suppression
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= '0;
        else if (push) last_q <= bus.dr_in;
    end
`else
    assign dup = 1'b0;
`endif

    // A full FIFO still accepts when the head is popped on the same edge
    assign push = bus.dr_valid && !dup && (!full || pop);
    assign drop = bus.dr_valid && !dup && full && !pop;

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.dr_in;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Transmit FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            shift_q <= shift_d;
        end
    end

    // Transmit FSM next state: LOAD pops, then 10 characters of START/DATA/STOP
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        char_d  = char_q;
        shift_d = shift_q;
        if (state_q == START || state_q == DATA || state_q == STOP)
            timer_d = tick ? '0 : timer_q + TW'(1);
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (count_q != '0) state_d = LOAD;
            end
            LOAD: begin
                shift_d = mem_q[rd_ptr_q];
                char_d  = '0;
                bit_d   = '0;
                timer_d = '0;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else bit_d = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (char_q != 4'd9) begin
                        // Next nibble moves into the top of the buffer
                        char_d  = char_q + 4'd1;
                        shift_d = {shift_q[27:0], 4'h0};
                        state_d = START;
                    end else begin
                        state_d = (count_q != '0) ? LOAD : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Current character: hex digit of the top nibble, then CR, then LF
    always_comb begin
        nib = shift_q[31:28];
        chr = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        if (char_q == 4'd8) chr = 8'h0D;
        if (char_q == 4'd9) chr = 8'h0A;
    end

    // Serial line: low for the start bit, data LSB first, otherwise idle high
    always_comb begin
        tx_w = 1'b1;
        case (state_q)
            START:   tx_w = 1'b0;
            DATA:    tx_w = chr[bit_q];
            default: tx_w = 1'b1;
        endcase
    end

    assign bus.tx       = tx_w;
    assign bus.busy     = (state_q != IDLE) || (count_q != '0);
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_debug_reg_tx.sv
// Scoreboard bench for debug_reg_tx: a timing-level reference model predicts
// accepted words, overflow and busy; a UART receiver decodes tx and compares
// every character against the expected-character queue.
module tb_debug_reg_tx;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int DRAIN_LIMIT = 20000;

    logic clk = 1'b0;
    logic rst;

    debug_reg_tx_if bus ();

    debug_reg_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_q[$];
    byte unsigned exp_chars[$];
    bit          m_ovf;
    bit          m_active;
    logic [31:0] m_last;
    longint      e = 0;
    longint      next_pop = -1;
    longint      frame_end = -1;
    longint      last_pop = -1;

    function automatic void model_reset();
        m_q.delete();
        exp_chars.delete();
        m_ovf     = 1'b0;
        m_active  = 1'b0;
        m_last    = '0;
        next_pop  = -1;
        frame_end = -1;
    endfunction

    function automatic void push_word(input logic [31:0] w);
        logic [3:0] n;
        for (int i = 0; i < 8; i++) begin
            n = w[31 - 4*i -: 4];
            if (n < 10) exp_chars.push_back(8'h30 + 8'(n));
            else        exp_chars.push_back(8'h41 + 8'(n) - 8'd10);
        end
        exp_chars.push_back(8'h0D);
        exp_chars.push_back(8'h0A);
    endfunction

    function automatic bit m_busy();
        return (m_q.size() != 0) || m_active;
    endfunction

    // One clock edge of the model, using pre-edge occupancy
    function automatic void model_step(input bit v, input logic [31:0] d);
        int sz;
        bit pop;
        bit dup;
        if (rst) begin
            model_reset();
            e++;
            return;
        end
        sz  = m_q.size();
        pop = (next_pop == e);
        dup = 1'b0;
`ifdef DEBUG_REG_TX_DEDUP_EN
        dup = v && (d == m_last);
`endif
        if (v && !dup) begin
            if (sz < DEPTH || pop) begin
                m_q.push_back(d);
                push_word(d);
                m_last = d;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) begin
            void'(m_q.pop_front());
            next_pop  = -1;
            m_active  = 1'b1;
            last_pop  = e;
            frame_end = e + 100*D;
        end else if (e == frame_end) begin
            if (sz > 0) next_pop = e + 1;
            else        m_active = 1'b0;
        end else if (!m_active && next_pop < 0 && sz > 0) begin
            next_pop = e + 1;
        end
        e++;
    endfunction

    task automatic cycle(input bit v, input logic [31:0] d);
        bus.dr_valid = v;
        bus.dr_in    = d;
        @(posedge clk);
        model_step(v, d);
        @(negedge clk);
        bus.dr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_busy() || exp_chars.size() != 0 || bus.busy) && n < DRAIN_LIMIT) begin
            cycle(1'b0, '0);
            n++;
        end
        chk("drain_timeout", 32'(n < DRAIN_LIMIT), 32'd1);
    endtask

    // ---------------- status monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(bus.busy), 32'(m_busy()));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // ---------------- UART receiver / character scoreboard ----------------
    int          rx_st = 0;
    int          rx_t;
    int          rx_idx = 0;
    int          rx_words = 0;
    logic [7:0]  rx_sh;
    longint      nc = 0;
    longint      rx_start, rx_prev_start;
    byte unsigned exp_c;

    always @(negedge clk) begin
        nc++;
        if (rst) begin
            rx_st  = 0;
            rx_idx = 0;
        end else if (rx_st == 0) begin
            if (bus.tx == 1'b0) begin
                rx_st    = 1;
                rx_t     = 0;
                rx_start = nc;
            end
        end else begin
            rx_t++;
            if (rx_t % D == D/2) begin
                if (rx_t / D >= 1 && rx_t / D <= 8) begin
                    rx_sh[rx_t / D - 1] = bus.tx;
                end else if (rx_t / D == 9) begin
                    chk("stop_bit", 32'(bus.tx), 32'd1);
                    if (exp_chars.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_char: got %0h expected none", rx_sh);
                    end else begin
                        exp_c = exp_chars.pop_front();
                        chk("char", 32'(rx_sh), 32'(exp_c));
                    end
                    if (rx_idx != 0) chk("char_gap", 32'(rx_start - rx_prev_start), 32'(10*D));
                    rx_prev_start = rx_start;
                    rx_idx = (rx_idx + 1) % 10;
                    if (rx_idx == 0) rx_words++;
                    rx_st = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int w0;
        logic [31:0] v0;
        logic [31:0] d;
        logic [31:0] prev;

        rst = 1'b1;
        bus.dr_valid = 1'b0;
        bus.dr_in    = '0;
        repeat (2) cycle(1'b0, '0);
        chk("reset_tx", 32'(bus.tx), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;

        // Single word: latency, exact frame length, then idle
        cycle(1'b1, 32'h12AB00FF);
        chk("lat_e0", 32'(bus.tx), 32'd1);
        cycle(1'b0, '0);
        chk("lat_e1", 32'(bus.tx), 32'd1);
        cycle(1'b0, '0);
        chk("lat_e2", 32'(bus.tx), 32'd0);
        n = 0;
        while (bus.busy && n < 1000) begin
            cycle(1'b0, '0);
            n++;
        end
        chk("frame_len", 32'(n), 32'd400);
        drain();

        // Back-to-back burst of six strobes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'hA0000000 + 32'(i));
        chk("burst_ovf", 32'(bus.overflow), 32'd1);
        drain();

        // Reset in the middle of character 3's data bits
        cycle(1'b1, 32'h3456789A);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        n = 0;
        while (e < last_pop + 33*D && n < 1000) begin
            cycle(1'b0, '0);
            n++;
        end
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("midreset_tx", 32'(bus.tx), 32'd1);
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_ovf", 32'(bus.overflow), 32'd0);
        repeat (2) cycle(1'b0, '0);
        rst = 1'b0;
`ifdef DEBUG_REG_TX_DEDUP_EN
        v0 = 32'h00000001;
`else
        v0 = 32'h00000000;
`endif
        cycle(1'b1, v0);
        chk("post_reset_lat_e0", 32'(bus.tx), 32'd1);
        cycle(1'b0, '0);
        chk("post_reset_lat_e1", 32'(bus.tx), 32'd1);
        cycle(1'b0, '0);
        chk("post_reset_lat_e2", 32'(bus.tx), 32'd0);
        drain();

        // Full FIFO with a strobe on the LOAD edge, then one on a non-pop edge
        cycle(1'b1, 32'hC0DE0001);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        for (int i = 2; i < 6; i++) cycle(1'b1, 32'hC0DE0000 + 32'(i));
        n = 0;
        while (e < last_pop + 100*D + 1 && n < 1000) begin
            cycle(1'b0, '0);
            n++;
        end
        cycle(1'b1, 32'hC0DE0006);
        chk("load_strobe_ovf", 32'(bus.overflow), 32'd0);
        cycle(1'b1, 32'hC0DE0007);
        chk("full_drop_ovf", 32'(bus.overflow), 32'd1);
        drain();

        // Repeated value: suppressed only with duplicate filtering built in
        w0 = rx_words;
        cycle(1'b1, 32'h5);
        cycle(1'b1, 32'h5);
        cycle(1'b1, 32'h6);
        drain();
`ifdef DEBUG_REG_TX_DEDUP_EN
        chk("dedup_words", 32'(rx_words - w0), 32'd2);
`else
        chk("dedup_words", 32'(rx_words - w0), 32'd3);
`endif

        // Randomized strobes, occasionally repeating the previous value
        prev = 32'h0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                d = ($urandom_range(0, 3) == 0) ? prev : 32'($urandom);
                prev = d;
                cycle(1'b1, d);
            end else begin
                cycle(1'b0, '0);
            end
        end
        drain();
        chk("leftover_chars", 32'(exp_chars.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
